multiplexer_2to1: RTL and testbench
===================================

// Module: multiplexer_2to1
// PURPOSE
//   Two-input, WIDTH-bit multiplexer: output c carries input a when sel=0 and input b when sel=1.
//   Default build registers the output on clk, giving a timing-clean 1-cycle select stage.
//   REG_OUT=0 gives a purely combinational path for glue logic.
//   Leaf datapath block, used wherever a 2-way source select is needed.
// PARAMETERS
//   WIDTH    1   bit width of a, b and c
//   REG_OUT  1   1 = output registered on rising clk; 0 = combinational output
// PORTS
//   clk        input   1      system clock; all state updates on its rising edge
//   rst_n      input   1      reset: asynchronous, active-low
//   a          input   WIDTH  data input 0, selected when sel=0
//   b          input   WIDTH  data input 1, selected when sel=1
//   sel        input   1      select: 0 -> a, 1 -> b
//   in_valid   input   1      qualifies a/b/sel in the current cycle
//   c          output  WIDTH  selected data
//   out_valid  output  1      c holds a valid selection
//   sel_q      output  1      sel value that produced the current c
// BEHAVIOUR
//   - Select function: c = sel ? b : a, bitwise across all WIDTH bits. No arithmetic, no width change.
//   - sel=X/Z is not supported; the bench drives only 0/1.
//   - REG_OUT=1:
//     - Reset: while rst_n=0, c=0, out_valid=0 and sel_q=0, applied immediately, independent of clk.
//     - Reset release: first capture occurs at the first rising clk edge after rst_n goes high.
//     - Latency: exactly 1 cycle. On each rising edge with in_valid=1: c <= sel?b:a, sel_q <= sel, out_valid <= 1.
//     - Edge with in_valid=0: c and sel_q hold their previous values; out_valid <= 0.
//     - Inputs changing between edges have no effect on c until the next edge.
//     - Simultaneous events: a, b and sel changing in the same cycle are captured together; no ordering hazard.
//     - Reset asserted mid-stream: outputs clear at once; no pending data survives.
//   - REG_OUT=0:
//     - Outputs are fully combinational: c = rst_n ? (sel?b:a) : 0; sel_q = rst_n & sel; out_valid = rst_n & in_valid.
//     - clk is unused.
//     - Any change on a, b or sel propagates to c within the same delta/timestep.
//   - No backpressure. Every valid input is accepted, and out_valid never stalls.
// TESTING
//   1. Reset:
//      - Stimulus: rst_n=0 with a=1, b=1, sel=1.
//      - Required: c=0, out_valid=0 immediately. After release and 1 edge with in_valid=1, c=1.
//   2. Truth table, WIDTH=1, REG_OUT=1, in_valid=1, applied one (a,b,sel) per cycle in this order:
//      - Stimulus: (0,0,0) (1,0,1) (0,1,0) (1,1,1) (1,0,0) (0,1,1) (1,1,0) (0,0,1).
//      - Required: c one cycle later = 0,0,0,1,1,1,1,0.
//   3. Wide data, WIDTH=8:
//      - Stimulus: a=8'hA5, b=8'h3C, sel toggling 0,1,0.
//      - Required: c = A5, 3C, A5, each with out_valid=1 one cycle after its input.
//   4. Hold:
//      - Stimulus: capture a=1 with sel=0, then in_valid=0 while a, b and sel all change.
//      - Required: c stays 1, out_valid=0, sel_q=0.
//   5. Reset mid-stream:
//      - Stimulus: drop rst_n between edges while c=1.
//      - Required: c=0 and out_valid=0 before the next clk edge.
//   6. REG_OUT=0:
//      - Stimulus: rst_n=1, sel switches 0->1 with a=0, b=1.
//      - Required: c goes 0->1 in the same timestep; out_valid tracks in_valid.

Source files
------------

// File: rtl/multiplexer_2to1.sv
// rtl/multiplexer_2to1.sv - two-input WIDTH-bit select with optional registered output stage
module multiplexer_2to1 #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
    output logic             sel_q
);

    logic [WIDTH-1:0] sel_data;

    assign sel_data = sel ? b : a;

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] c_q;
            logic             valid_q;
            logic             sel_r;

            // Data and sel hold across idle cycles; only the valid flag tracks in_valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c_q     <= '0;
                    valid_q <= 1'b0;
                    sel_r   <= 1'b0;
                end else begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        c_q   <= sel_data;
                        sel_r <= sel;
                    end
                end
            end

            assign c         = c_q;
            assign out_valid = valid_q;
            assign sel_q     = sel_r;
        end else begin : g_comb
            logic unused_clk;

            assign unused_clk = clk;
            assign c          = rst_n ? sel_data : '0;
            assign out_valid  = rst_n & in_valid;
            assign sel_q      = rst_n & sel;
        end
    endgenerate

endmodule

// File: tb/tb_multiplexer_2to1.sv
// tb/tb_multiplexer_2to1.sv - self-checking bench for multiplexer_2to1 (registered and combinational builds)
module tb_multiplexer_2to1;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       in_valid;
    logic       a1, b1, c1, ov1, sq1;
    logic [7:0] a8, b8, c8;
    logic       ov8, sq8;
    logic       ac, bc, selc, ivc, cc, ovc, sqc;

    int n_checks = 0;
    int n_errors = 0;

    multiplexer_2to1 #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel), .in_valid(in_valid),
        .c(c1), .out_valid(ov1), .sel_q(sq1)
    );

    multiplexer_2to1 #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel), .in_valid(in_valid),
        .c(c8), .out_valid(ov8), .sel_q(sq8)
    );

    multiplexer_2to1 #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .a(ac), .b(bc), .sel(selc), .in_valid(ivc),
        .c(cc), .out_valid(ovc), .sel_q(sqc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: the output is the selection of the most recent accepted transaction,
    // and out_valid reports whether the most recent edge saw a valid transaction.
    typedef struct packed {
        logic       a1;
        logic       b1;
        logic [7:0] a8;
        logic [7:0] b8;
        logic       sel;
    } xact_t;

    xact_t acc      = '0;
    bit    have_acc = 1'b0;
    bit    last_vld = 1'b0;

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            last_vld = in_valid;
            if (in_valid) begin
                acc      = '{a1: a1, b1: b1, a8: a8, b8: b8, sel: sel};
                have_acc = 1'b1;
            end
        end
    end

    always @(negedge rst_n) begin
        have_acc = 1'b0;
        last_vld = 1'b0;
    end

    always @(posedge clk) begin
        logic       e_c1, e_sel, e_cc;
        logic [7:0] e_c8;
        #2;
        e_c1  = have_acc ? (acc.sel ? acc.b1 : acc.a1) : 1'b0;
        e_c8  = have_acc ? (acc.sel ? acc.b8 : acc.a8) : 8'h00;
        e_sel = have_acc ? acc.sel : 1'b0;
        e_cc  = (rst_n === 1'b1) ? (selc ? bc : ac) : 1'b0;
        chk("mdl_c1",  c1,  e_c1);
        chk("mdl_ov1", ov1, last_vld);
        chk("mdl_sq1", sq1, e_sel);
        chk("mdl_c8",  c8,  e_c8);
        chk("mdl_ov8", ov8, last_vld);
        chk("mdl_sq8", sq8, e_sel);
        chk("mdl_cc",  cc,  e_cc);
        chk("mdl_ovc", ovc, (rst_n === 1'b1) & ivc);
        chk("mdl_sqc", sqc, (rst_n === 1'b1) & selc);
    end

    logic [2:0] tt_vec [8] = '{3'b000, 3'b101, 3'b010, 3'b111, 3'b100, 3'b011, 3'b110, 3'b001};
    logic       tt_exp [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       wd_sel [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] wd_exp [3] = '{8'hA5, 8'h3C, 8'hA5};

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; sel = 1'b1;
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        ac = 1'b1; bc = 1'b1; selc = 1'b1; ivc = 1'b1;

        #3;
        chk("rst_c1",  c1,  1'b0);
        chk("rst_ov1", ov1, 1'b0);
        chk("rst_sq1", sq1, 1'b0);
        chk("rst_c8",  c8,  8'h00);
        chk("rst_cc",  cc,  1'b0);
        chk("rst_ovc", ovc, 1'b0);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #3;
        chk("rel_c1",  c1,  1'b1);
        chk("rel_ov1", ov1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a1, b1, sel} = tt_vec[i];
            in_valid = 1'b1;
            @(posedge clk) #3;
            chk("tt_c1",  c1,  tt_exp[i]);
            chk("tt_ov1", ov1, 1'b1);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a8 = 8'hA5; b8 = 8'h3C; sel = wd_sel[i]; in_valid = 1'b1;
            @(posedge clk) #3;
            chk("wide_c8",  c8,  wd_exp[i]);
            chk("wide_ov8", ov8, 1'b1);
        end

        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; sel = 1'b0; in_valid = 1'b1;
        @(posedge clk) #3;
        chk("hold_cap", c1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0; a1 = 1'(i); b1 = 1'b1; sel = 1'b1; a8 = 8'(i + 8'h11); b8 = 8'h77;
            @(posedge clk) #3;
            chk("hold_c1",  c1,  1'b1);
            chk("hold_ov1", ov1, 1'b0);
            chk("hold_sq1", sq1, 1'b0);
        end

        @(negedge clk);
        a1 = 1'b1; sel = 1'b0; in_valid = 1'b1;
        @(posedge clk) #3;
        chk("mid_pre", c1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_c1",  c1,  1'b0);
        chk("mid_ov1", ov1, 1'b0);
        chk("mid_c8",  c8,  8'h00);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;

        @(negedge clk);
        ac = 1'b0; bc = 1'b1; selc = 1'b0; ivc = 1'b1;
        #1;
        chk("comb_c0",  cc,  1'b0);
        chk("comb_ov1", ovc, 1'b1);
        selc = 1'b1;
        #1;
        chk("comb_c1",  cc,  1'b1);
        chk("comb_sq",  sqc, 1'b1);
        ivc = 1'b0;
        #1;
        chk("comb_ov0", ovc, 1'b0);

        @(negedge clk);
        ivc = 1'b1; rst_n = 1'b0;
        #1;
        chk("comb_rst_c",  cc,  1'b0);
        chk("comb_rst_sq", sqc, 1'b0);
        chk("comb_rst_ov", ovc, 1'b0);
        #1 rst_n = 1'b1;

        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
